// File: rtl/sub_share_pkg.sv
// Shared types and helpers for the subtractor-sharing arbiter.
// Holds the slot state encoding and the round-robin pick function.
package sub_share_pkg;

    localparam int RR_MAX  = 32;
    localparam int RR_IDXW = 5;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // One-hot grant: first valid index at or above ptr, wrapping at nreq.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0]  valid,
        input logic [RR_IDXW-1:0] ptr,
        input logic [RR_IDXW:0]   nreq
    );
        logic [RR_MAX-1:0] g;
        logic [RR_IDXW:0]  idx;
        logic              found;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX; k++) begin
            idx = {1'b0, ptr} + k[RR_IDXW:0];
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            if (k[RR_IDXW:0] < nreq && !found && valid[idx[RR_IDXW-1:0]]) begin
                g[idx[RR_IDXW-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/param_subtractor.sv
// Unsigned subtractor: diff = (a - b) mod 2^WIDTH, borrow = (a < b).
module param_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/sub_share_arbiter.sv
// Round-robin share of one param_subtractor among NREQ requesters,
// with a single-entry id-tagged result slot.
module sub_share_arbiter
    import sub_share_pkg::*;
#(
    parameter int   WIDTH = 8,
    parameter int   NREQ  = 4,
    localparam int  IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_diff,
    output logic                  resp_borrow
);

    slot_state_t         state;
    slot_state_t         state_nxt;
    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      ptr_nxt;
    logic [IDW-1:0]      gnt_id;
    logic [NREQ-1:0]     grant;
    logic [WIDTH-1:0]    gnt_a;
    logic [WIDTH-1:0]    gnt_b;
    logic [WIDTH-1:0]    sub_diff;
    logic                sub_borrow;
    logic                can_accept;
    logic                accept;
    logic [RR_MAX-1:0]   valid_ext;
    logic [RR_MAX-1:0]   pick;
    logic [RR_IDXW-1:0]  ptr_ext;

    always_comb begin
        valid_ext = '0;
        valid_ext[NREQ-1:0] = req_valid;
        ptr_ext = '0;
        ptr_ext[IDW-1:0] = rr_ptr;
        pick  = rr_pick(valid_ext, ptr_ext, (RR_IDXW+1)'(NREQ));
        grant = pick[NREQ-1:0];
    end

    always_comb begin
        gnt_id = '0;
        gnt_a  = '0;
        gnt_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_id = IDW'(i);
                gnt_a  = req_a[i*WIDTH +: WIDTH];
                gnt_b  = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_nxt = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

    assign can_accept = (state == EMPTY) | resp_ready;
    // Held at zero during reset so no grant is visible before the first edge.
    assign req_ready  = rst_n ? (grant & {NREQ{can_accept}}) : '0;
    assign accept     = |req_ready;
    assign resp_valid = (state == FULL);

    param_subtractor #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a      (gnt_a),
        .b      (gnt_b),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (!accept && resp_ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            resp_id     <= '0;
            resp_diff   <= '0;
            resp_borrow <= 1'b0;
        end else if (accept) begin
            rr_ptr      <= ptr_nxt;
            resp_id     <= gnt_id;
            resp_diff   <= sub_diff;
            resp_borrow <= sub_borrow;
        end
    end

endmodule
